rom_fetch_ctrl: RTL and testbench

ROM_FETCH_CTRL -- requirements
Module: rom_fetch_ctrl

---
 rtl/rom_fetch_ctrl.sv | 174 +++++++++++++++++
 tb/tb_rom_fetch_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_fetch_ctrl.sv
// rom_fetch_ctrl: sequences instruction fetches from a combinational switch ROM.
// After driving the address A, the controller waits SETTLE_CYCLES cycles for the
// ROM data to settle. It then captures Q into IR and PC and advances A.
//
// Parameters:
//   SETTLE_CYCLES  0..3, wait cycles between driving A and sampling Q
//   HALT_ON_WRAP   1 = stop free-running fetch when A increments 4'hF -> 4'h0
// Optional feature macro:
//   FETCH_SINGLE_STEP_EN  when defined, STEP fetches one word from IDLE;
//                         when undefined, STEP is present but ignored
// Ports:
//   CLK, RST_N       clock (rising edge), asynchronous active-low reset
//   A        out 4   ROM address
//   Q        in  8   ROM data (combinational function of A)
//   RUN      in  1   level, fetch continuously while high
//   STEP     in  1   pulse, fetch a single word
//   LOAD     in  1   jump request; LD_ADDR becomes the next fetch address
//   LD_ADDR  in  4   jump target
//   IR       out 8   last fetched word
//   PC       out 4   address IR was fetched from
//   IR_VALID out 1   one-cycle pulse per fetched word
//   HALT     out 1   high while the FSM is in IDLE
//   WRAP     out 1   one-cycle pulse when A increments 4'hF -> 4'h0
module rom_fetch_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned HALT_ON_WRAP  = 0
) (
    input  logic       CLK,
    input  logic       RST_N,
    output logic [3:0] A,
    input  logic [7:0] Q,
    input  logic       RUN,
    input  logic       STEP,
    input  logic       LOAD,
    input  logic [3:0] LD_ADDR,
    output logic [7:0] IR,
    output logic [3:0] PC,
    output logic       IR_VALID,
    output logic       HALT,
    output logic       WRAP
);

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned CW = 2;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SETTLE  = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;

    // Counter preload so that SETTLE lasts exactly SETTLE_CYCLES cycles
    localparam logic [CW-1:0] CNT_INIT =
        (SETTLE_CYCLES > 0) ? CW'(SETTLE_CYCLES - 1) : CW'(0);
    // First state of a fetch: SETTLE is skipped entirely with zero settle time
    localparam logic [1:0] ST_FETCH =
        (SETTLE_CYCLES == 0) ? ST_CAPTURE : ST_SETTLE;
    localparam logic HOW_EN = (HALT_ON_WRAP != 0);

    logic [1:0]    r_state, w_state_nxt;
    logic [CW-1:0] r_cnt,   w_cnt_nxt;
    logic [AW-1:0] r_addr,  w_addr_nxt;
    logic [DW-1:0] r_ir,    w_ir_nxt;
    logic [AW-1:0] r_pc,    w_pc_nxt;
    logic          r_ir_valid, w_ir_valid_nxt;
    logic          r_halt,  w_halt_nxt;
    logic          r_wrap,  w_wrap_nxt;
    logic          r_stop,  w_stop_nxt;

    logic          w_step;
    logic          w_run_ok;
    logic          w_is_wrap;
    logic [AW-1:0] w_addr_inc;

`ifdef FETCH_SINGLE_STEP_EN
    assign w_step = STEP;
`else
    // Single-step disabled: keep the port but tie its effect off
    logic w_unused_step;
    assign w_unused_step = STEP;
    assign w_step        = 1'b0;
`endif

    // RUN only counts while no wrap-stop is pending
    assign w_run_ok   = RUN && !r_stop;
    assign w_addr_inc = AW'(r_addr + AW'(1));
    // A jump overrides the increment, so a LOAD to 4'h0 never reports a wrap
    assign w_is_wrap  = (r_addr == 4'hF) && !LOAD;

    // Next-state and registered-output logic
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_addr_nxt     = r_addr;
        w_ir_nxt       = r_ir;
        w_pc_nxt       = r_pc;
        w_ir_valid_nxt = 1'b0;
        w_wrap_nxt     = 1'b0;
        w_stop_nxt     = RUN ? r_stop : 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (LOAD) begin
                    w_addr_nxt = LD_ADDR;
                end
                if (w_run_ok || w_step) begin
                    w_state_nxt = ST_FETCH;
                    w_cnt_nxt   = CNT_INIT;
                end
            end
            ST_SETTLE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_CAPTURE;
                end else begin
                    w_cnt_nxt = CW'(r_cnt - CW'(1));
                end
            end
            ST_CAPTURE: begin
                w_ir_nxt       = Q;
                w_pc_nxt       = r_addr;
                w_ir_valid_nxt = 1'b1;
                w_addr_nxt     = LOAD ? LD_ADDR : w_addr_inc;
                w_wrap_nxt     = w_is_wrap;
                if (HOW_EN && w_is_wrap) begin
                    w_state_nxt = ST_IDLE;
                    w_stop_nxt  = 1'b1;
                end else if (w_run_ok) begin
                    w_state_nxt = ST_FETCH;
                    w_cnt_nxt   = CNT_INIT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase

        w_halt_nxt = (w_state_nxt == ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_ir       <= '0;
            r_pc       <= '0;
            r_ir_valid <= 1'b0;
            r_halt     <= 1'b1;
            r_wrap     <= 1'b0;
            r_stop     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_addr     <= w_addr_nxt;
            r_ir       <= w_ir_nxt;
            r_pc       <= w_pc_nxt;
            r_ir_valid <= w_ir_valid_nxt;
            r_halt     <= w_halt_nxt;
            r_wrap     <= w_wrap_nxt;
            r_stop     <= w_stop_nxt;
        end
    end

    assign A        = r_addr;
    assign IR       = r_ir;
    assign PC       = r_pc;
    assign IR_VALID = r_ir_valid;
    assign HALT     = r_halt;
    assign WRAP     = r_wrap;

endmodule

// File: tb/tb_rom_fetch_ctrl.sv
// Bench for rom_fetch_ctrl. Four instances share the stimulus; each is fed by a ROM
// with mem[i] = 8'h0i:
//   0: SETTLE_CYCLES=1              1: SETTLE_CYCLES=1, HALT_ON_WRAP=1
//   2: SETTLE_CYCLES=0              3: SETTLE_CYCLES=3
// Only the instance selected by `sel` is checked. Expected fetches are queued
// when the stimulus is driven. Each IR_VALID pops the queue and compares the
// fetched word, PC, WRAP and the cycle of the fetch.
module tb_rom_fetch_ctrl;

    typedef struct {
        logic [7:0] ir;
        logic [3:0] pc;
        logic       wrap;
        int         cyc;
    } exp_t;

    typedef struct {
        logic       go;
        logic [3:0] ld;
        logic [7:0] ir;
        logic [3:0] pc;
        logic       wrap;
        logic [3:0] a;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       run;
    logic       step;
    logic       load;
    logic [3:0] ld_addr;

    logic [3:0] a_o    [4];
    logic [7:0] ir_o   [4];
    logic [3:0] pc_o   [4];
    logic       v_o    [4];
    logic       halt_o [4];
    logic       wrap_o [4];

    logic [1:0] sel;
    logic [3:0] m_a;
    logic [7:0] m_ir;
    logic [3:0] m_pc;
    logic       m_valid;
    logic       m_halt;
    logic       m_wrap;

    exp_t       sbq[$];
    vec_t       tbl[5];
    int         n_chk = 0;
    int         n_bad = 0;
    int         cyc   = 0;
    bit         a_chk = 1'b0;
    logic [3:0] prev_a = 4'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    rom_fetch_ctrl #(.SETTLE_CYCLES(1), .HALT_ON_WRAP(0)) u_s1 (
        .CLK(clk), .RST_N(rst_n), .A(a_o[0]), .Q({4'h0, a_o[0]}), .RUN(run),
        .STEP(step), .LOAD(load), .LD_ADDR(ld_addr), .IR(ir_o[0]), .PC(pc_o[0]),
        .IR_VALID(v_o[0]), .HALT(halt_o[0]), .WRAP(wrap_o[0]));

    rom_fetch_ctrl #(.SETTLE_CYCLES(1), .HALT_ON_WRAP(1)) u_how (
        .CLK(clk), .RST_N(rst_n), .A(a_o[1]), .Q({4'h0, a_o[1]}), .RUN(run),
        .STEP(step), .LOAD(load), .LD_ADDR(ld_addr), .IR(ir_o[1]), .PC(pc_o[1]),
        .IR_VALID(v_o[1]), .HALT(halt_o[1]), .WRAP(wrap_o[1]));

    rom_fetch_ctrl #(.SETTLE_CYCLES(0), .HALT_ON_WRAP(0)) u_s0 (
        .CLK(clk), .RST_N(rst_n), .A(a_o[2]), .Q({4'h0, a_o[2]}), .RUN(run),
        .STEP(step), .LOAD(load), .LD_ADDR(ld_addr), .IR(ir_o[2]), .PC(pc_o[2]),
        .IR_VALID(v_o[2]), .HALT(halt_o[2]), .WRAP(wrap_o[2]));

    rom_fetch_ctrl #(.SETTLE_CYCLES(3), .HALT_ON_WRAP(0)) u_s3 (
        .CLK(clk), .RST_N(rst_n), .A(a_o[3]), .Q({4'h0, a_o[3]}), .RUN(run),
        .STEP(step), .LOAD(load), .LD_ADDR(ld_addr), .IR(ir_o[3]), .PC(pc_o[3]),
        .IR_VALID(v_o[3]), .HALT(halt_o[3]), .WRAP(wrap_o[3]));

    always_comb begin
        m_a     = a_o[sel];
        m_ir    = ir_o[sel];
        m_pc    = pc_o[sel];
        m_valid = v_o[sel];
        m_halt  = halt_o[sel];
        m_wrap  = wrap_o[sel];
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [7:0] ir, input logic [3:0] pc, input logic wrap,
                        input int at);
        exp_t e;
        e.ir   = ir;
        e.pc   = pc;
        e.wrap = wrap;
        e.cyc  = at;
        sbq.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reset all instances and select the one to be checked
    task automatic do_reset(input logic [1:0] s);
        rst_n   = 1'b0;
        run     = 1'b0;
        step    = 1'b0;
        load    = 1'b0;
        ld_addr = 4'h0;
        #1;
        sel     = s;
        tick(2);
        rst_n   = 1'b1;
        tick(1);
    endtask

    // Scoreboard monitor: every fetch pulse must match the head of the queue
    always @(negedge clk) begin : mon
        exp_t e;
        if (m_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                n_chk++;
                n_bad++;
                $display("FAIL unexpected_fetch: got IR='h%0h PC='h%0h, expected no fetch (cycle %0d)",
                         m_ir, m_pc, cyc);
            end else begin
                e = sbq.pop_front();
                chk("fetch_ir",   int'(m_ir),   int'(e.ir));
                chk("fetch_pc",   int'(m_pc),   int'(e.pc));
                chk("fetch_wrap", int'(m_wrap), int'(e.wrap));
                chk("fetch_cyc",  cyc,          e.cyc);
            end
        end else begin
            if (m_wrap === 1'b1) chk("stray_wrap", 1, 0);
            if (a_chk) chk("a_stable", int'(m_a), int'(prev_a));
        end
        prev_a <= m_a;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end of the sequence");
        $fatal(1);
    end

    initial begin
        int c0;
        int c1;
        tbl[0] = '{1'b0, 4'h7, 8'h00, 4'h0, 1'b0, 4'h7};
        tbl[1] = '{1'b1, 4'h5, 8'h05, 4'h5, 1'b0, 4'h6};
        tbl[2] = '{1'b1, 4'hF, 8'h0F, 4'hF, 1'b1, 4'h0};
        tbl[3] = '{1'b1, 4'h0, 8'h00, 4'h0, 1'b0, 4'h1};
        tbl[4] = '{1'b1, 4'h9, 8'h09, 4'h9, 1'b0, 4'hA};

        sel     = 2'd0;
        rst_n   = 1'b0;
        run     = 1'b0;
        step    = 1'b0;
        load    = 1'b0;
        ld_addr = 4'h0;
        tick(2);

        // Reset values
        chk("rst_a",     int'(m_a),     0);
        chk("rst_pc",    int'(m_pc),    0);
        chk("rst_ir",    int'(m_ir),    0);
        chk("rst_valid", int'(m_valid), 0);
        chk("rst_wrap",  int'(m_wrap),  0);
        for (int k = 0; k < 4; k++) chk("rst_halt", int'(halt_o[k]), 1);

        // Free-running fetch over a full address wrap
        rst_n = 1'b1;
        tick(1);
        c0 = cyc;
        for (int n = 0; n < 17; n++)
            push({4'h0, 4'(n)}, 4'(n), (n == 15), c0 + 3 + 2 * n);
        a_chk = 1'b1;
        run   = 1'b1;
        tick(33);
        run   = 1'b0;
        tick(4);
        a_chk = 1'b0;
        chk("run_drained", sbq.size(), 0);
        chk("run_halt",    int'(m_halt), 1);
        chk("run_a",       int'(m_a),    1);

        // Single-step pulses
        do_reset(2'd0);
        for (int k = 0; k < 3; k++) begin
            c0 = cyc;
`ifdef FETCH_SINGLE_STEP_EN
            push({4'h0, 4'(k)}, 4'(k), 1'b0, c0 + 3);
`endif
            step = 1'b1;
            tick(1);
            step = 1'b0;
            tick(5);
            chk("step_halt", int'(m_halt), 1);
        end
        chk("step_drained", sbq.size(), 0);
`ifdef FETCH_SINGLE_STEP_EN
        chk("step_a", int'(m_a), 3);
`else
        chk("step_a", int'(m_a), 0);
`endif

        // Jump during CAPTURE of address 3; a LOAD during SETTLE is ignored
        do_reset(2'd0);
        c0 = cyc;
        push(8'h00, 4'h0, 1'b0, c0 + 3);
        push(8'h01, 4'h1, 1'b0, c0 + 5);
        push(8'h02, 4'h2, 1'b0, c0 + 7);
        push(8'h03, 4'h3, 1'b0, c0 + 9);
        push(8'h0A, 4'hA, 1'b0, c0 + 11);
        push(8'h0B, 4'hB, 1'b0, c0 + 13);
        a_chk   = 1'b1;
        run     = 1'b1;
        tick(3);
        load    = 1'b1;
        ld_addr = 4'h6;
        tick(1);
        load    = 1'b0;
        tick(4);
        load    = 1'b1;
        ld_addr = 4'hA;
        tick(1);
        load    = 1'b0;
        tick(2);
        run     = 1'b0;
        tick(4);
        a_chk   = 1'b0;
        chk("jump_drained", sbq.size(), 0);
        chk("jump_a",       int'(m_a),   'hC);

        // Table: LOAD in IDLE, optionally with a one-cycle RUN pulse
        for (int i = 0; i < 5; i++) begin
            c0 = cyc;
            if (tbl[i].go) push(tbl[i].ir, tbl[i].pc, tbl[i].wrap, c0 + 3);
            load    = 1'b1;
            ld_addr = tbl[i].ld;
            run     = tbl[i].go;
            tick(1);
            load    = 1'b0;
            run     = 1'b0;
            tick(4);
            chk("tbl_a",       int'(m_a),    int'(tbl[i].a));
            chk("tbl_halt",    int'(m_halt), 1);
            chk("tbl_drained", sbq.size(),   0);
            if (tbl[i].go) chk("tbl_ir", int'(m_ir), int'(tbl[i].ir));
        end

        // Reset asserted while in SETTLE at address 5
        load    = 1'b1;
        ld_addr = 4'h5;
        run     = 1'b1;
        tick(1);
        load    = 1'b0;
        run     = 1'b0;
        chk("mid_pre_a",    int'(m_a),    5);
        chk("mid_pre_halt", int'(m_halt), 0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_a",     int'(m_a),     0);
        chk("mid_rst_ir",    int'(m_ir),    0);
        chk("mid_rst_pc",    int'(m_pc),    0);
        chk("mid_rst_halt",  int'(m_halt),  1);
        chk("mid_rst_valid", int'(m_valid), 0);
        tick(3);
        rst_n = 1'b1;
        tick(5);
        chk("mid_post_a",       int'(m_a),    0);
        chk("mid_post_halt",    int'(m_halt), 1);
        chk("mid_post_drained", sbq.size(),   0);

        // Stop on wrap, then resume after RUN is seen low
        do_reset(2'd1);
        c0 = cyc;
        for (int n = 0; n < 16; n++)
            push({4'h0, 4'(n)}, 4'(n), (n == 15), c0 + 3 + 2 * n);
        a_chk = 1'b1;
        run   = 1'b1;
        tick(40);
        chk("how_stop_drained", sbq.size(),   0);
        chk("how_stop_halt",    int'(m_halt), 1);
        chk("how_stop_a",       int'(m_a),    0);
        run = 1'b0;
        tick(1);
        c1 = cyc;
        push(8'h00, 4'h0, 1'b0, c1 + 3);
        push(8'h01, 4'h1, 1'b0, c1 + 5);
        run = 1'b1;
        tick(3);
        run = 1'b0;
        tick(4);
        a_chk = 1'b0;
        chk("how_resume_drained", sbq.size(),   0);
        chk("how_resume_halt",    int'(m_halt), 1);
        chk("how_resume_a",       int'(m_a),    2);

        // Zero settle cycles: one fetch per cycle
        do_reset(2'd2);
        c0 = cyc;
        for (int n = 0; n < 5; n++) push({4'h0, 4'(n)}, 4'(n), 1'b0, c0 + 2 + n);
        a_chk = 1'b1;
        run   = 1'b1;
        tick(5);
        run   = 1'b0;
        tick(3);
        a_chk = 1'b0;
        chk("s0_drained", sbq.size(), 0);
        chk("s0_a",       int'(m_a),  5);

        // Three settle cycles: one fetch every four cycles
        do_reset(2'd3);
        c0 = cyc;
        for (int n = 0; n < 3; n++) push({4'h0, 4'(n)}, 4'(n), 1'b0, c0 + 5 + 4 * n);
        a_chk = 1'b1;
        run   = 1'b1;
        tick(9);
        run   = 1'b0;
        tick(6);
        a_chk = 1'b0;
        chk("s3_drained", sbq.size(),   0);
        chk("s3_a",       int'(m_a),    3);
        chk("s3_halt",    int'(m_halt), 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
